mult_div_unit: RTL



---
 rtl/mult_div_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative HI/LO multiply/divide unit (shift-add / restoring divide)
// Signed MULT/DIV via magnitude and sign fix-up is built only when MD_SIGNED_EN is defined.
module mult_div_unit #(
  parameter int WIDTH      = 32,
  parameter int ITERATIONS = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       MDOperation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             WriteHI,
  input  logic             WriteLO,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_step, res;
  logic [WIDTH-1:0]   opd;
  logic               is_div;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_rem, div_diff;

`ifdef MD_SIGNED_EN
  logic sgn, neg_q, neg_r;
  assign sgn   = MDOperation[0];
  assign mag_a = (sgn && A[WIDTH-1]) ? -A : A;
  assign mag_b = (sgn && B[WIDTH-1]) ? -B : B;

  // neg_q flips product/quotient, neg_r gives the remainder the dividend's sign
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && Start) begin
      neg_q <= sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
      neg_r <= sgn && A[WIDTH-1];
    end
  end

  always_comb begin
    if (!is_div)
      res = neg_q ? -acc : acc;
    else
      res = {neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH],
             neg_q ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0]};
  end
`else
  logic unused_op;
  assign unused_op = MDOperation[0];
  assign mag_a     = A;
  assign mag_b     = B;
  assign res       = acc;
`endif

  // Multiply: {product_hi, multiplier} shifts right; divide: {remainder, dividend} shifts left
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opd : '0)};
    div_rem  = acc[2*WIDTH-1:WIDTH-1];
    div_diff = div_rem - {1'b0, opd};
    if (!is_div)
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    else if (!div_diff[WIDTH])
      acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_step = {div_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = CALC;
      CALC:    if (cnt == '0) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      acc     <= '0;
      opd     <= '0;
      is_div  <= 1'b0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          // A write coinciding with Start lands now and is overwritten at FIN
          if (WriteHI) HI <= WriteData;
          if (WriteLO) LO <= WriteData;
          if (Start) begin
            is_div  <= MDOperation[1];
            cnt     <= CW'(ITERATIONS - 1);
            DivZero <= MDOperation[1] && (B == '0);
            acc     <= MDOperation[1] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
            opd     <= MDOperation[1] ? mag_b : mag_a;
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt - CW'(1);
        end
        FIN: begin
          HI   <= res[2*WIDTH-1:WIDTH];
          LO   <= res[WIDTH-1:0];
          Done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Busy = (state != IDLE);

endmodule
